hack_sequencer: RTL

HACK_SEQUENCER -- requirements
Module: hack_sequencer

---
 rtl/hack_pkg.sv | 45 ++++
 rtl/hack_jump_eval.sv | 17 +
 rtl/hack_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack CPU control sequencer.
package hack_pkg;

    typedef enum logic [2:0] {
        StRst,
        StFetch,
        StMrd,
        StExec,
        StMwr,
        StHalt
    } state_e;

    localparam int unsigned InstrW  = 16;

    // Instruction field positions
    localparam int unsigned IdxType = 15;
    localparam int unsigned IdxA    = 12;
    localparam int unsigned CompHi  = 11;
    localparam int unsigned CompLo  = 6;
    localparam int unsigned CompW   = CompHi - CompLo + 1;
    localparam int unsigned DestA   = 5;
    localparam int unsigned DestD   = 4;
    localparam int unsigned DestM   = 3;
    localparam int unsigned JumpHi  = 2;
    localparam int unsigned JumpLo  = 0;

    // Bit positions within the jump field
    localparam int unsigned JmpBitLt = 2;
    localparam int unsigned JmpBitEq = 1;
    localparam int unsigned JmpBitGt = 0;

    localparam logic [2:0] JmpNull   = 3'b000;
    localparam logic [2:0] JmpGt     = 3'b001;
    localparam logic [2:0] JmpEq     = 3'b010;
    localparam logic [2:0] JmpGe     = 3'b011;
    localparam logic [2:0] JmpLt     = 3'b100;
    localparam logic [2:0] JmpNe     = 3'b101;
    localparam logic [2:0] JmpLe     = 3'b110;
    localparam logic [2:0] JmpAlways = 3'b111;

    function automatic logic is_c_instr(input logic [InstrW-1:0] w);
        return w[IdxType];
    endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational jump condition: selects on ALU sign/zero flags using the 3-bit jump field.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0] jump_i,
    input  logic       zr_i,
    input  logic       ng_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = (jump_i[JmpBitLt] & ng_i)
                | (jump_i[JmpBitEq] & zr_i)
                | (jump_i[JmpBitGt] & ~ng_i & ~zr_i);
    end

endmodule

// File: rtl/hack_sequencer.sv
// Multi-cycle control sequencer for a Hack CPU: fetch, optional M read, execute, optional M write.
module hack_sequencer
    import hack_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    input  logic              mem_ack,
    input  logic              alu_zr,
    input  logic              alu_ng,
    input  logic              halt_req,
    output logic              ifetch_req,
    output logic [15:0]       ir,
    output logic              pc_ld,
    output logic              pc_incr,
    output logic              pc_rst,
    output logic              a_ld,
    output logic              a_sel,
    output logic              d_ld,
    output logic [5:0]        alu_ctl,
    output logic              alu_y_sel,
    output logic              m_rd_req,
    output logic              m_wr,
    output logic              mdr_ld,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [InstrW-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               commit;
    logic               taken;

    hack_jump_eval u_jump_eval (
        .jump_i  (ir_q[JumpHi:JumpLo]),
        .zr_i    (alu_zr),
        .ng_i    (alu_ng),
        .taken_o (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        ifetch_req = 1'b0;
        pc_ld      = 1'b0;
        pc_incr    = 1'b0;
        pc_rst     = 1'b0;
        a_ld       = 1'b0;
        a_sel      = 1'b0;
        d_ld       = 1'b0;
        alu_ctl    = '0;
        alu_y_sel  = 1'b0;
        m_rd_req   = 1'b0;
        m_wr       = 1'b0;
        mdr_ld     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            StRst: begin
                pc_rst  = 1'b1;
                state_d = halt_req ? StHalt : StFetch;
            end
            StFetch: begin
                ifetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = (instr[IdxType] & instr[IdxA]) ? StMrd : StExec;
                end
            end
            StMrd: begin
                m_rd_req = 1'b1;
                if (mem_ack) begin
                    mdr_ld  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!is_c_instr(ir_q)) begin
                    a_ld    = 1'b1;
                    pc_incr = 1'b1;
                    commit  = 1'b1;
                end else begin
                    alu_ctl   = ir_q[CompHi:CompLo];
                    alu_y_sel = ir_q[IdxA];
                    if (ir_q[DestM]) begin
                        state_d = StMwr;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            StMwr: begin
                m_wr      = 1'b1;
                alu_ctl   = ir_q[CompHi:CompLo];
                alu_y_sel = ir_q[IdxA];
                commit    = mem_ack;
            end
            StHalt: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StRst;
        endcase

        // All register writes of a C-instruction land on the same edge, so PC picks up old A.
        if (commit) begin
            cnt_d   = cnt_q + CntOne;
            state_d = halt_req ? StHalt : StFetch;
            if (is_c_instr(ir_q)) begin
                a_ld    = ir_q[DestA];
                a_sel   = 1'b1;
                d_ld    = ir_q[DestD];
                pc_ld   = taken;
                pc_incr = ~taken;
            end
        end
    end

    assign ir        = ir_q;
    assign instr_cnt = cnt_q;

endmodule
